// File: rtl/alu_issue_if.sv
// Handshake/data bundle between the ID/EX issue stage, its upstream decode
// source and the downstream EX-stage ALU.
// Optional: ALU_ISSUE_ILLEGAL_TRAP_EN adds the out_illegal flag.
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_insn;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_op;
    logic [XLEN-1:0] out_oprd1;
    logic [XLEN-1:0] out_oprd2;
    logic            out_is_branch;
    logic            out_branch_inv;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic            out_illegal;
`endif

    // Driver side: upstream instruction source plus the EX consumer.
    modport master (
        output in_valid, in_insn, in_rs1_data, in_rs2_data, flush, out_ready,
        input  in_ready, out_valid, out_op, out_oprd1, out_oprd2,
               out_is_branch, out_branch_inv
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
             , out_illegal
`endif
    );

    // Stage side.
    modport slave (
        input  in_valid, in_insn, in_rs1_data, in_rs2_data, flush, out_ready,
        output in_ready, out_valid, out_op, out_oprd1, out_oprd2,
               out_is_branch, out_branch_inv
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
             , out_illegal
`endif
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a RISC-V instruction into a 4-bit ALU op,
// selects the operands and holds them in a single-entry valid/ready register.
// Optional: define ALU_ISSUE_ILLEGAL_TRAP_EN to issue illegal instructions
// flagged with out_illegal; otherwise they are consumed and dropped.
module alu_issue_stage #(
    parameter int         XLEN     = 32,
    parameter logic [3:0] RESET_OP = 4'b0000
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1000;

    // Shared R/I funct3 map; returns {legal, op}.
    function automatic logic [4:0] arith_op(input logic [2:0] f3);
        case (f3)
            3'b000:  arith_op = {1'b1, OP_ADD};
            3'b010:  arith_op = {1'b1, OP_SLT};
            3'b100:  arith_op = {1'b1, OP_XOR};
            3'b110:  arith_op = {1'b1, OP_OR};
            3'b111:  arith_op = {1'b1, OP_AND};
            default: arith_op = {1'b0, RESET_OP};
        endcase
    endfunction

    logic [31:0]       insn;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic              unused_rs_fields;

    assign insn             = bus.in_insn;
    assign opcode           = insn[6:0];
    assign funct3           = insn[14:12];
    assign funct7           = insn[31:25];
    assign imm_i            = insn[31:20];
    assign imm_s            = {insn[31:25], insn[11:7]};
    assign unused_rs_fields = ^insn[24:15];

    logic            dec_legal;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_oprd2;
    logic            dec_br;
    logic            dec_inv;
    logic [4:0]      ar;

    // Decode the incoming word into op, operand 2 and branch flags.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = RESET_OP;
        dec_oprd2 = '0;
        dec_br    = 1'b0;
        dec_inv   = 1'b0;
        ar        = arith_op(funct3);
        case (opcode)
            OPC_R: begin
                dec_oprd2 = bus.in_rs2_data;
                dec_op    = ar[3:0];
                if (funct7 == 7'b0000000) begin
                    dec_legal = ar[4];
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_SUB;
                end
            end
            OPC_I: begin
                dec_oprd2 = XLEN'(imm_i);
                dec_op    = ar[3:0];
                dec_legal = ar[4];
            end
            OPC_LD: begin
                dec_oprd2 = XLEN'(imm_i);
                dec_op    = OP_ADD;
                dec_legal = 1'b1;
            end
            OPC_ST: begin
                dec_oprd2 = XLEN'(imm_s);
                dec_op    = OP_ADD;
                dec_legal = 1'b1;
            end
            OPC_BR: begin
                dec_oprd2 = bus.in_rs2_data;
                dec_br    = 1'b1;
                case (funct3)
                    3'b000:  begin dec_legal = 1'b1; dec_op = OP_SUB; dec_inv = 1'b0; end
                    3'b001:  begin dec_legal = 1'b1; dec_op = OP_SUB; dec_inv = 1'b1; end
                    3'b100:  begin dec_legal = 1'b1; dec_op = OP_SLT; dec_inv = 1'b1; end
                    3'b101:  begin dec_legal = 1'b1; dec_op = OP_SLT; dec_inv = 1'b0; end
                    default: begin dec_legal = 1'b0; dec_br = 1'b0; end
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic            valid_p1;
    logic [3:0]      op_p1;
    logic [XLEN-1:0] oprd1_p1;
    logic [XLEN-1:0] oprd2_p1;
    logic            br_p1;
    logic            inv_p1;
    logic            in_ready;
    logic            accept;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic            illegal_p1;
`endif

    assign in_ready = !valid_p1 || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !bus.flush;

    // ---- stage boundary: ID -> EX pipeline register ----
    // Flush wins; otherwise load on accept, or empty when EX drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_p1   <= 1'b0;
            op_p1      <= RESET_OP;
            oprd1_p1   <= '0;
            oprd2_p1   <= '0;
            br_p1      <= 1'b0;
            inv_p1     <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            illegal_p1 <= 1'b0;
`endif
        end else if (bus.flush) begin
            valid_p1   <= 1'b0;
            op_p1      <= RESET_OP;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            illegal_p1 <= 1'b0;
`endif
        end else if (accept) begin
            if (dec_legal) begin
                valid_p1   <= 1'b1;
                op_p1      <= dec_op;
                oprd1_p1   <= bus.in_rs1_data;
                oprd2_p1   <= dec_oprd2;
                br_p1      <= dec_br;
                inv_p1     <= dec_inv;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                illegal_p1 <= 1'b0;
`endif
            end else begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                valid_p1   <= 1'b1;
                op_p1      <= RESET_OP;
                oprd1_p1   <= '0;
                oprd2_p1   <= '0;
                br_p1      <= 1'b0;
                inv_p1     <= 1'b0;
                illegal_p1 <= 1'b1;
`else
                // Consumed but never issued: the slot simply goes empty.
                valid_p1   <= 1'b0;
`endif
            end
        end else if (bus.out_ready) begin
            valid_p1 <= 1'b0;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = valid_p1;
    assign bus.out_op         = op_p1;
    assign bus.out_oprd1      = oprd1_p1;
    assign bus.out_oprd2      = oprd2_p1;
    assign bus.out_is_branch  = br_p1;
    assign bus.out_branch_inv = inv_p1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign bus.out_illegal    = illegal_p1;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model,
// per-cycle compare, directed literal checks and randomized traffic.
module tb_alu_issue_stage;
    localparam int         XLEN     = 32;
    localparam logic [3:0] RESET_OP = 4'b0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(XLEN)) bus ();

    alu_issue_stage #(.XLEN(XLEN), .RESET_OP(RESET_OP)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic        inv;
        logic        ill;
    } ent_t;

    // Reference decode straight from the instruction-set rules.
    function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] a,
                                        input logic [31:0] b, output bit legal);
        ent_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] immi;
        logic [31:0] imms;
        logic [3:0] f3op [8];
        bit f3ok [8];
        e = '0;
        legal = 0;
        opc = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        immi = {{20{w[31]}}, w[31:20]};
        imms = {{20{w[31]}}, w[31:25], w[11:7]};
        for (int i = 0; i < 8; i++) begin f3op[i] = 4'h0; f3ok[i] = 0; end
        f3op[0] = 4'd2; f3ok[0] = 1;
        f3op[2] = 4'd7; f3ok[2] = 1;
        f3op[4] = 4'd8; f3ok[4] = 1;
        f3op[6] = 4'd1; f3ok[6] = 1;
        f3op[7] = 4'd0; f3ok[7] = 1;
        e.a = a;
        if (opc == 7'h33) begin
            e.b = b;
            if (f7 == 7'h00 && f3ok[f3]) begin legal = 1; e.op = f3op[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1; e.op = 4'd6; end
        end else if (opc == 7'h13) begin
            e.b = immi;
            if (f3ok[f3]) begin legal = 1; e.op = f3op[f3]; end
        end else if (opc == 7'h03) begin
            legal = 1; e.op = 4'd2; e.b = immi;
        end else if (opc == 7'h23) begin
            legal = 1; e.op = 4'd2; e.b = imms;
        end else if (opc == 7'h63) begin
            e.b = b; e.br = 1;
            if (f3 == 3'd0) begin legal = 1; e.op = 4'd6; e.inv = 0; end
            if (f3 == 3'd1) begin legal = 1; e.op = 4'd6; e.inv = 1; end
            if (f3 == 3'd4) begin legal = 1; e.op = 4'd7; e.inv = 1; end
            if (f3 == 3'd5) begin legal = 1; e.op = 4'd7; e.inv = 0; end
        end
        return e;
    endfunction

    // Model state: queue of entries awaiting EX, and the fields currently shown.
    ent_t q[$];
    ent_t shown;
    bit   m_rdy;
    bit   m_legal;
    ent_t m_e;

    // Advance the reference model on each clock edge or asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            shown = '0;
            shown.op = RESET_OP;
        end else begin
            m_rdy = (q.size() == 0) || bus.out_ready;
            if (bus.flush) begin
                q.delete();
                shown.op = RESET_OP;
                shown.ill = 0;
            end else begin
                if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && m_rdy) begin
                    m_e = ref_decode(bus.in_insn, bus.in_rs1_data, bus.in_rs2_data, m_legal);
                    if (m_legal) begin
                        shown = m_e;
                        q.push_back(m_e);
                    end else begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                        shown = '0;
                        shown.op = RESET_OP;
                        shown.ill = 1;
                        q.push_back(shown);
`endif
                    end
                end
            end
        end
    end

    // Compare every DUT output against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", bus.in_ready, (q.size() == 0) || bus.out_ready);
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("out_op", bus.out_op, shown.op);
        chk("out_oprd1", bus.out_oprd1, shown.a);
        chk("out_oprd2", bus.out_oprd2, shown.b);
        chk("out_is_branch", bus.out_is_branch, shown.br);
        chk("out_branch_inv", bus.out_branch_inv, shown.inv);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        chk("out_illegal", bus.out_illegal, shown.ill);
`endif
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_insn   = w;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return w;
    endfunction

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_XORI = 32'hFFF0C193;
    localparam logic [31:0] I_SW   = 32'hFE20AE23;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BGE  = 32'h0020D463;
    localparam logic [31:0] I_SLL  = 32'h002091B3;

    logic [31:0] sw_insn [7];
    logic [3:0]  sw_op   [7];
    logic [31:0] sw_b    [7];
    logic        sw_br   [7];
    logic        sw_inv  [7];

    initial begin
        bus.in_rs1_data = 32'h00000005;
        bus.in_rs2_data = 32'hFFFFFFFD;
        drive(0, 32'h0, 0, 0);
        sw_insn = '{I_ADD, I_SUB, I_SLT, I_XORI, I_SW, I_BNE, I_BGE};
        sw_op   = '{4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b0010, 4'b0110, 4'b0111};
        sw_b    = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF,
                    32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFD};
        sw_br   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        sw_inv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset asserted while an entry is stalled.
        drive(1, I_ADD, 0, 0);
        tick();
        chk("lit_load_valid", bus.out_valid, 1'b1);
        drive(0, I_ADD, 0, 0);
        tick();
        chk("lit_stall_valid", bus.out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("lit_rst_valid", bus.out_valid, 1'b0);
        chk("lit_rst_op", bus.out_op, RESET_OP);
        chk("lit_rst_oprd1", bus.out_oprd1, 32'h0);
        chk("lit_rst_oprd2", bus.out_oprd2, 32'h0);
        chk("lit_rst_br", bus.out_is_branch, 1'b0);
        tick();
        rst_n = 1'b1;

        // Decode sweep, one instruction per cycle.
        for (int i = 0; i < 7; i++) begin
            drive(1, sw_insn[i], 1, 0);
            tick();
            chk("lit_sweep_valid", bus.out_valid, 1'b1);
            chk("lit_sweep_op", bus.out_op, sw_op[i]);
            chk("lit_sweep_oprd1", bus.out_oprd1, 32'h5);
            chk("lit_sweep_oprd2", bus.out_oprd2, sw_b[i]);
            chk("lit_sweep_br", bus.out_is_branch, sw_br[i]);
            chk("lit_sweep_inv", bus.out_branch_inv, sw_inv[i]);
        end

        // Backpressure: second instruction waits three cycles, then enters.
        drive(1, I_ADD, 1, 0);
        tick();
        drive(1, I_SUB, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_bp_ready", bus.in_ready, 1'b0);
            chk("lit_bp_hold_op", bus.out_op, 4'b0010);
            chk("lit_bp_hold_valid", bus.out_valid, 1'b1);
        end
        drive(1, I_SUB, 1, 0);
        #1 chk("lit_bp_ready_back", bus.in_ready, 1'b1);
        tick();
        chk("lit_bp_second_op", bus.out_op, 4'b0110);
        chk("lit_bp_second_valid", bus.out_valid, 1'b1);
        drive(0, I_SUB, 1, 0);
        tick();
        chk("lit_bp_drained", bus.out_valid, 1'b0);

        // Flush of a stalled entry with a concurrent input.
        drive(1, I_XORI, 1, 0);
        tick();
        drive(0, I_XORI, 0, 0);
        tick();
        drive(1, I_SLT, 0, 1);
        tick();
        chk("lit_flush_valid", bus.out_valid, 1'b0);
        chk("lit_flush_op", bus.out_op, RESET_OP);
        drive(0, I_SLT, 1, 0);
        tick();
        chk("lit_flush_no_issue", bus.out_valid, 1'b0);

        // Illegal sll following a valid entry.
        drive(1, I_ADD, 1, 0);
        tick();
        drive(1, I_SLL, 1, 0);
        #1 chk("lit_ill_ready", bus.in_ready, 1'b1);
        tick();
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        chk("lit_ill_valid", bus.out_valid, 1'b1);
        chk("lit_ill_flag", bus.out_illegal, 1'b1);
        chk("lit_ill_op", bus.out_op, 4'b0000);
`else
        chk("lit_ill_valid", bus.out_valid, 1'b0);
`endif
        drive(0, I_SLL, 1, 0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.in_rs1_data = $urandom;
            bus.in_rs2_data = $urandom;
            drive($urandom_range(0, 3) != 0, rand_insn(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            tick();
        end

        drive(0, 32'h0, 1, 0);
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
